// File: rtl/matmul_scheduler.sv
// Sequences C = A*B over an operand buffer and streams C row-major on an AXI-Stream port.
// Define MATMUL_SCHED_SATURATE_EN to clamp each accumulation instead of wrapping it.
module matmul_scheduler #(
    parameter int DATA_W = 32,
    parameter int DIM_W  = 4,
    parameter int ADDR_W = 8
) (
    input  logic              ACLK,
    input  logic              ARESET,
    input  logic              start,
    input  logic [DIM_W-1:0]  cfg_m,
    input  logic [DIM_W-1:0]  cfg_n,
    input  logic [DIM_W-1:0]  cfg_k,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr_a,
    output logic [ADDR_W-1:0] rd_addr_b,
    input  logic [DATA_W-1:0] rd_data_a,
    input  logic [DATA_W-1:0] rd_data_b,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              m_axis_tlast,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DRAIN, S_EMIT, S_DONE} state_t;

    state_t r_state, w_next;

    logic [DIM_W-1:0]  r_m, r_n, r_k;
    logic [DIM_W-1:0]  r_i, r_j, r_kk;
    logic [ADDR_W-1:0] r_row_a, r_addr_a, r_addr_b;
    logic              r_vld_p1, r_first_p1;
    logic signed [DATA_W-1:0] r_acc_p2;

    logic w_kk_last, w_i_last, w_j_last, w_zero_cfg;
    logic [ADDR_W-1:0] w_k_ext, w_n_ext;

    assign w_kk_last  = (r_kk == r_k - DIM_W'(1));
    assign w_i_last   = (r_i == r_m - DIM_W'(1));
    assign w_j_last   = (r_j == r_n - DIM_W'(1));
    assign w_zero_cfg = (cfg_m == '0) || (cfg_n == '0) || (cfg_k == '0);
    assign w_k_ext    = ADDR_W'(r_k);
    assign w_n_ext    = ADDR_W'(r_n);

    function automatic logic signed [DATA_W-1:0] f_mac(
        input logic signed [DATA_W-1:0] acc,
        input logic signed [DATA_W-1:0] a,
        input logic signed [DATA_W-1:0] b,
        input logic                     first
    );
`ifdef MATMUL_SCHED_SATURATE_EN
        localparam int W2 = 2 * DATA_W;
        localparam logic signed [W2-1:0] SMAX = {{(DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
        localparam logic signed [W2-1:0] SMIN = {{(DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
        logic signed [W2-1:0] w_sum;
        w_sum = W2'(a) * W2'(b);
        if (!first) w_sum = w_sum + W2'(acc);
        if (w_sum > SMAX)      w_sum = SMAX;
        else if (w_sum < SMIN) w_sum = SMIN;
        return w_sum[DATA_W-1:0];
`else
        logic signed [DATA_W-1:0] w_prod;
        w_prod = a * b;
        return first ? w_prod : acc + w_prod;
`endif
    endfunction

    always_ff @(posedge ACLK) begin
        if (ARESET) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = w_zero_cfg ? S_DONE : S_FETCH;
            S_FETCH: if (w_kk_last) w_next = S_DRAIN;
            S_DRAIN: w_next = S_EMIT;
            S_EMIT:  if (m_axis_tready) w_next = (w_i_last && w_j_last) ? S_DONE : S_FETCH;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        rd_en         = 1'b0;
        rd_addr_a     = '0;
        rd_addr_b     = '0;
        m_axis_tvalid = 1'b0;
        m_axis_tdata  = '0;
        m_axis_tlast  = 1'b0;
        busy          = (r_state != S_IDLE);
        done          = (r_state == S_DONE);
        if (r_state == S_FETCH) begin
            rd_en     = 1'b1;
            rd_addr_a = r_addr_a;
            rd_addr_b = r_addr_b;
        end
        if (r_state == S_EMIT) begin
            m_axis_tvalid = 1'b1;
            m_axis_tdata  = r_acc_p2;
            m_axis_tlast  = w_i_last && w_j_last;
        end
    end

    // Loop indices and address walkers: A steps by 1, B steps by N, rows of A step by K
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_m      <= '0;
            r_n      <= '0;
            r_k      <= '0;
            r_i      <= '0;
            r_j      <= '0;
            r_kk     <= '0;
            r_row_a  <= '0;
            r_addr_a <= '0;
            r_addr_b <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_m      <= cfg_m;
                        r_n      <= cfg_n;
                        r_k      <= cfg_k;
                        r_i      <= '0;
                        r_j      <= '0;
                        r_kk     <= '0;
                        r_row_a  <= '0;
                        r_addr_a <= '0;
                        r_addr_b <= '0;
                    end
                end
                S_FETCH: begin
                    r_kk     <= w_kk_last ? '0 : r_kk + DIM_W'(1);
                    r_addr_a <= r_addr_a + ADDR_W'(1);
                    r_addr_b <= r_addr_b + w_n_ext;
                end
                S_EMIT: begin
                    if (m_axis_tready) begin
                        if (w_j_last) begin
                            r_j      <= '0;
                            r_i      <= r_i + DIM_W'(1);
                            r_row_a  <= r_row_a + w_k_ext;
                            r_addr_a <= r_row_a + w_k_ext;
                            r_addr_b <= '0;
                        end else begin
                            r_j      <= r_j + DIM_W'(1);
                            r_addr_a <= r_row_a;
                            r_addr_b <= ADDR_W'(r_j) + ADDR_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Stage p1: operands return one cycle after the read strobe
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_vld_p1   <= 1'b0;
            r_first_p1 <= 1'b0;
        end else begin
            r_vld_p1   <= (r_state == S_FETCH);
            r_first_p1 <= (r_kk == '0);
        end
    end

    // Stage p2: multiply-accumulate; the first term of each element reloads the accumulator
    always_ff @(posedge ACLK) begin
        if (ARESET) r_acc_p2 <= '0;
        else if (r_vld_p1)
            r_acc_p2 <= f_mac(r_acc_p2, $signed(rd_data_a), $signed(rd_data_b), r_first_p1);
    end

endmodule

// File: tb/tb_matmul_scheduler.sv
// Randomized and directed bench for matmul_scheduler against a loop-based matrix product model.
module tb_matmul_scheduler;
    localparam int DATA_W = 32;
    localparam int DIM_W  = 4;
    localparam int ADDR_W = 8;

    logic              ACLK = 1'b0;
    logic              ARESET;
    logic              start;
    logic [DIM_W-1:0]  cfg_m, cfg_n, cfg_k;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr_a, rd_addr_b;
    logic [DATA_W-1:0] rd_data_a, rd_data_b;
    logic [DATA_W-1:0] m_axis_tdata;
    logic              m_axis_tvalid, m_axis_tready, m_axis_tlast;
    logic              busy, done;

    matmul_scheduler #(.DATA_W(DATA_W), .DIM_W(DIM_W), .ADDR_W(ADDR_W)) dut (
        .ACLK(ACLK), .ARESET(ARESET), .start(start),
        .cfg_m(cfg_m), .cfg_n(cfg_n), .cfg_k(cfg_k),
        .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
        .busy(busy), .done(done)
    );

    always #5 ACLK = ~ACLK;

    logic [DATA_W-1:0] mem_a [256];
    logic [DATA_W-1:0] mem_b [256];

    always @(posedge ACLK) begin
        if (rd_en) begin
            rd_data_a <= mem_a[rd_addr_a];
            rd_data_b <= mem_b[rd_addr_b];
        end
    end

    int n_chk = 0;
    int n_pass = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [31:0] ref_elem(input int i, input int j, input int n, input int k);
`ifdef MATMUL_SCHED_SATURATE_EN
        longint s = 0;
        for (int kk = 0; kk < k; kk++) begin
            int a = mem_a[i*k+kk];
            int b = mem_b[kk*n+j];
            s = s + longint'(a) * longint'(b);
            if (s > 64'sd2147483647)  s = 64'sd2147483647;
            if (s < -64'sd2147483648) s = -64'sd2147483648;
        end
        return s[31:0];
`else
        int s = 0;
        for (int kk = 0; kk < k; kk++) begin
            int a = mem_a[i*k+kk];
            int b = mem_b[kk*n+j];
            s = s + a * b;
        end
        return s;
`endif
    endfunction

    task automatic fill_rand(input bit big);
        for (int x = 0; x < 256; x++) begin
            mem_a[x] = big ? $urandom : $urandom_range(0, 200) - 100;
            mem_b[x] = big ? $urandom : $urandom_range(0, 200) - 100;
        end
    endtask

    // rmode: 0 = tready always high, 1 = random tready, 2 = hold tready low for the first 5 EMIT cycles
    task automatic run(input int m, input int n, input int k, input int rmode);
        logic [31:0] expq[$];
        logic [31:0] prev_data, want;
        bit nz, prev_stall, done_seen, any_rd, any_v;
        int c, beats, last_hs, stall;
        nz = (m != 0) && (n != 0) && (k != 0);
        if (nz)
            for (int i = 0; i < m; i++)
                for (int j = 0; j < n; j++)
                    expq.push_back(ref_elem(i, j, n, k));
        beats = 0; last_hs = 0; stall = 0;
        prev_stall = 0; done_seen = 0; any_rd = 0; any_v = 0; prev_data = '0;
        @(negedge ACLK);
        cfg_m = DIM_W'(m); cfg_n = DIM_W'(n); cfg_k = DIM_W'(k); start = 1'b1;
        @(negedge ACLK);
        start = 1'b0;
        cfg_m = DIM_W'($urandom); cfg_n = DIM_W'($urandom); cfg_k = DIM_W'($urandom);
        c = 1;
        while (c <= 3000 && !done_seen) begin
            if (c == 1 && nz) begin
                check_eq("first_rd_en", rd_en, 1);
                check_eq("first_addr", {rd_addr_a, rd_addr_b}, 0);
            end
            start = (c == 2 && nz);
            any_rd |= rd_en;
            any_v  |= m_axis_tvalid;
            if (m_axis_tvalid) check_eq("rd_en_in_emit", rd_en, 0);
            if (prev_stall) begin
                check_eq("stall_tvalid", m_axis_tvalid, 1);
                check_eq("stall_tdata", m_axis_tdata, prev_data);
            end
            case (rmode)
                0: m_axis_tready = 1'b1;
                1: m_axis_tready = ($urandom_range(0, 2) != 0);
                default: begin
                    if (m_axis_tvalid && stall < 5) begin
                        m_axis_tready = 1'b0;
                        stall++;
                    end else m_axis_tready = 1'b1;
                end
            endcase
            if (m_axis_tvalid && m_axis_tready) begin
                beats++;
                want = (expq.size() > 0) ? expq.pop_front() : 32'hDEAD_BEEF;
                check_eq($sformatf("tdata[%0d]", beats), m_axis_tdata, want);
                check_eq($sformatf("tlast[%0d]", beats), m_axis_tlast, expq.size() == 0);
                if (rmode == 0)
                    check_eq("beat_cycle", c, (beats == 1) ? k + 2 : last_hs + k + 2);
                else if (rmode == 2 && beats > 1)
                    check_eq("beat_cycle", c, last_hs + k + 2);
                last_hs = c;
            end
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_data  = m_axis_tdata;
            if (done) begin
                done_seen = 1;
                if (nz) check_eq("done_cycle", c, last_hs + 1);
                else    check_eq("done_early", c <= 2, 1);
            end else begin
                @(negedge ACLK);
                c++;
            end
        end
        start = 1'b0;
        check_eq("done_seen", done_seen, 1);
        check_eq("beat_count", beats, nz ? m * n : 0);
        if (!nz) check_eq("zero_no_traffic", {any_rd, any_v}, 0);
        @(negedge ACLK);
        check_eq("idle_after_done", {busy, done}, 0);
        m_axis_tready = 1'b1;
    endtask

    function automatic logic [52:0] all_outs();
        return {rd_en, rd_addr_a, rd_addr_b, m_axis_tvalid, m_axis_tlast, m_axis_tdata, busy, done};
    endfunction

    initial begin
        ARESET = 1'b1; start = 1'b0; m_axis_tready = 1'b1;
        cfg_m = '0; cfg_n = '0; cfg_k = '0;
        fill_rand(0);
        repeat (3) @(negedge ACLK);
        check_eq("reset_outs", all_outs(), 0);
        ARESET = 1'b0;

        mem_a[0] = 3; mem_b[0] = 4;
        run(1, 1, 1, 0);

        mem_a[0] = 1; mem_a[1] = 2; mem_a[2] = 3; mem_a[3] = 4;
        mem_b[0] = 1; mem_b[1] = 0; mem_b[2] = 0; mem_b[3] = 1;
        run(2, 2, 2, 0);
        run(2, 2, 2, 2);

        run(2, 2, 0, 0);
        run(0, 3, 3, 0);

        mem_a[0] = 32'h7FFF_FFFF; mem_a[1] = 2;
        mem_b[0] = 32'h7FFF_FFFF; mem_b[1] = 2;
        run(1, 1, 2, 0);

        // Reset in the FETCH of the second element of a 2x2x2 run
        mem_a[0] = 1; mem_a[1] = 2; mem_a[2] = 3; mem_a[3] = 4;
        mem_b[0] = 5; mem_b[1] = 6; mem_b[2] = 7; mem_b[3] = 8;
        @(negedge ACLK);
        cfg_m = 2; cfg_n = 2; cfg_k = 2; start = 1'b1;
        @(negedge ACLK);
        start = 1'b0;
        repeat (4) @(negedge ACLK);
        check_eq("midrun_fetch", rd_en, 1);
        ARESET = 1'b1;
        @(negedge ACLK);
        check_eq("midrun_reset_outs", all_outs(), 0);
        ARESET = 1'b0;
        for (int x = 0; x < 6; x++) begin
            @(negedge ACLK);
            check_eq("post_reset_quiet", {m_axis_tvalid, busy}, 0);
        end
        run(2, 2, 2, 0);

        for (int r = 0; r < 8; r++) begin
            fill_rand(r[0]);
            run($urandom_range(1, 4), $urandom_range(1, 4), $urandom_range(1, 5), (r % 3 == 0) ? 0 : 1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
